tlu_emulator: RTL and testbench

Synthesizable stand-in for the EUDET-style Trigger Logic Unit at the far end of the TRIGGER / BUSY / TRIGGER_CLOCK link of the kc705 readout. It issues periodic or forced triggers on TRIGGER, waits for the readout's BUSY, and serially returns the trigger number clocked by the readout's TRIGGER_CLOCK. It lets the trigger path be exercised on the bench and in loopback without a physical TLU. It sits after the LVDS buffers, so all ports are single-ended.

---
 rtl/tlu_emulator.sv | 122 ++++++++++++
 tb/tb_tlu_emulator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_emulator.sv
// tlu_emulator: stand-in Trigger Logic Unit that raises TRIGGER, waits for BUSY and shifts back the trigger number
module tlu_emulator #(
    parameter int TRIG_PERIOD  = 10000,
    parameter int ID_WIDTH     = 15,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                force_trig,
    input  logic                busy,
    input  logic                trigger_clock,
    output logic                trigger,
    output logic [ID_WIDTH-1:0] trig_id,
    output logic [31:0]         trig_count,
    output logic [15:0]         veto_count,
    output logic                timeout_err
);
    localparam int PW = $clog2(TRIG_PERIOD);
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam int IW = $clog2(ID_WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, SHIFT, WAIT_RELEASE} state_t;

    state_t                state_q;
    logic [PW-1:0]         per_q;
    logic [TW-1:0]         to_q;
    logic [IW-1:0]         idx_q;
    logic                  trigger_q;
    logic [ID_WIDTH-1:0]   trig_id_q;
    logic [31:0]           trig_count_q;
    logic [15:0]           veto_count_q;
    logic                  timeout_err_q;
    logic                  busy_s1_q, busy_s_q;
    logic                  tclk_s1_q, tclk_s_q, tclk_d_q, tclk_rise_q;
    logic                  attempt;

    assign attempt     = force_trig || (enable && per_q == PW'(TRIG_PERIOD - 1));
    assign trigger     = trigger_q;
    assign trig_id     = trig_id_q;
    assign trig_count  = trig_count_q;
    assign veto_count  = veto_count_q;
    assign timeout_err = timeout_err_q;

    // Two-stage synchronizers for the readout's asynchronous lines, plus a registered TRIGGER_CLOCK rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_s1_q   <= 1'b0;
            busy_s_q    <= 1'b0;
            tclk_s1_q   <= 1'b0;
            tclk_s_q    <= 1'b0;
            tclk_d_q    <= 1'b0;
            tclk_rise_q <= 1'b0;
        end else begin
            busy_s1_q   <= busy;
            busy_s_q    <= busy_s1_q;
            tclk_s1_q   <= trigger_clock;
            tclk_s_q    <= tclk_s1_q;
            tclk_d_q    <= tclk_s_q;
            tclk_rise_q <= tclk_s_q & ~tclk_d_q;
        end
    end

    // Handshake sequencer; a busy drop in SHIFT or WAIT_RELEASE always completes the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            per_q         <= '0;
            to_q          <= '0;
            idx_q         <= '0;
            trigger_q     <= 1'b0;
            trig_id_q     <= '0;
            trig_count_q  <= '0;
            veto_count_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (attempt) begin
                        per_q <= '0;
                        if (busy_s_q) begin
                            veto_count_q <= (&veto_count_q) ? veto_count_q : veto_count_q + 16'd1;
                        end else begin
                            trigger_q <= 1'b1;
                            to_q      <= '0;
                            state_q   <= WAIT_BUSY;
                        end
                    end else begin
                        per_q <= enable ? per_q + 1'b1 : '0;
                    end
                end
                WAIT_BUSY: begin
                    if (busy_s_q) begin
                        trigger_q <= 1'b0;
                        idx_q     <= '0;
                        state_q   <= SHIFT;
                    end else if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        trigger_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: begin
                    if (!busy_s_q) begin
                        trigger_q    <= 1'b0;
                        trig_id_q    <= trig_id_q + 1'b1;
                        trig_count_q <= trig_count_q + 32'd1;
                        state_q      <= IDLE;
                    end else if (tclk_rise_q) begin
                        trigger_q <= (state_q == SHIFT) && trig_id_q[idx_q];
                        if (state_q == SHIFT) begin
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == IW'(ID_WIDTH - 1)) state_q <= WAIT_RELEASE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tlu_emulator.sv
// tb_tlu_emulator: directed handshakes against two emulators (15-bit and 4-bit IDs) sharing one readout model
module tb_tlu_emulator;
    localparam int P  = 100;
    localparam int TO = 64;

    logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, force_trig = 1'b0, busy = 1'b0, trigger_clock = 1'b0;
    logic        trg_a, trg_b, err_a, err_b;
    logic [14:0] id_a;
    logic [3:0]  id_b;
    logic [31:0] cnt_a, cnt_b;
    logic [15:0] veto_a, veto_b;
    int          n_pass = 0, n_chk = 0;

    tlu_emulator #(.TRIG_PERIOD(P), .ID_WIDTH(15), .BUSY_TIMEOUT(TO)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_trig(force_trig), .busy(busy),
        .trigger_clock(trigger_clock), .trigger(trg_a), .trig_id(id_a), .trig_count(cnt_a),
        .veto_count(veto_a), .timeout_err(err_a));

    tlu_emulator #(.TRIG_PERIOD(P), .ID_WIDTH(4), .BUSY_TIMEOUT(TO)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_trig(force_trig), .busy(busy),
        .trigger_clock(trigger_clock), .trigger(trg_b), .trig_id(id_b), .trig_count(cnt_b),
        .veto_count(veto_b), .timeout_err(err_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: phase 0 idle, 1 awaiting busy, 2 handshake after busy (bits counted by nb)
    int     m_mode[2], m_per[2], m_tmo[2], m_nb[2], m_trg[2], m_id[2], m_veto[2], m_err[2];
    longint m_cnt[2];
    logic   hb[2];
    logic   ht[4];
    logic   mb, mr;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_per[i] = 0; m_tmo[i] = 0; m_nb[i] = 0; m_trg[i] = 0;
                m_id[i] = 0; m_veto[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
            end
            hb = '{default: 1'b0};
            ht = '{default: 1'b0};
        end else begin
            mb = hb[1];
            mr = ht[2] & ~ht[3];
            for (int i = 0; i < 2; i++) begin
                int w;
                w = (i == 0) ? 15 : 4;
                if (m_mode[i] == 0) begin
                    if (force_trig || (enable && m_per[i] == P - 1)) begin
                        m_per[i] = 0;
                        if (mb) m_veto[i] = (m_veto[i] == 65535) ? 65535 : m_veto[i] + 1;
                        else begin m_trg[i] = 1; m_tmo[i] = 0; m_mode[i] = 1; end
                    end else m_per[i] = enable ? m_per[i] + 1 : 0;
                end else if (m_mode[i] == 1) begin
                    m_tmo[i]++;
                    if (mb) begin m_trg[i] = 0; m_nb[i] = 0; m_mode[i] = 2; end
                    else if (m_tmo[i] == TO) begin m_err[i] = 1; m_trg[i] = 0; m_mode[i] = 0; end
                end else begin
                    if (!mb) begin
                        m_trg[i] = 0; m_id[i] = (m_id[i] + 1) & ((1 << w) - 1); m_cnt[i]++; m_mode[i] = 0;
                    end else if (mr) begin
                        m_trg[i] = (m_nb[i] < w) ? ((m_id[i] >> m_nb[i]) & 1) : 0;
                        m_nb[i]++;
                    end
                end
            end
            hb[1] = hb[0]; hb[0] = busy;
            ht[3] = ht[2]; ht[2] = ht[1]; ht[1] = ht[0]; ht[0] = trigger_clock;
        end
    end

    // Every-cycle comparison of both emulators against the model
    initial begin
        #1;
        forever begin
            @(negedge clk);
            chk("a_trigger", trg_a, m_trg[0]);
            chk("a_trig_id", id_a, m_id[0]);
            chk("a_trig_count", cnt_a, m_cnt[0] & 32'hFFFFFFFF);
            chk("a_veto_count", veto_a, m_veto[0]);
            chk("a_timeout_err", err_a, m_err[0]);
            chk("b_trigger", trg_b, m_trg[1]);
            chk("b_trig_id", id_b, m_id[1]);
            chk("b_trig_count", cnt_b, m_cnt[1] & 32'hFFFFFFFF);
            chk("b_veto_count", veto_b, m_veto[1]);
            chk("b_timeout_err", err_b, m_err[1]);
        end
    end

    task automatic wait_level(input logic lvl, input int lim, output int n);
        n = 0;
        while (trg_a !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse();
        force_trig = 1'b1;
        @(negedge clk);
        force_trig = 1'b0;
    endtask

    // Readout side: raise busy, clock out np bits, sample each just before the next rising edge, release
    task automatic handshake(input int dly, input int np, input int h, input int l,
                             output logic [14:0] ba, output logic [3:0] bb, output int blat);
        ba = '0;
        bb = '0;
        repeat (dly) @(negedge clk);
        busy = 1'b1;
        wait_level(1'b0, 20, blat);
        for (int k = 0; k < np; k++) begin
            trigger_clock = 1'b1;
            repeat (h) @(negedge clk);
            trigger_clock = 1'b0;
            repeat (l) @(negedge clk);
            ba[k] = trg_a;
            if (k < 4) bb[k] = trg_b;
        end
        busy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        int          n, bl, hi;
        logic [14:0] ba;
        logic [3:0]  bb;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_trigger", trg_a, 0);
        chk("reset_id", id_a, 0);
        chk("reset_count", cnt_a, 0);
        chk("reset_veto", veto_a, 0);
        chk("reset_err", err_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pulse();
        wait_level(1'b0, 200, n);
        chk("timeout_high_cycles", n, 64);
        chk("timeout_err_set", err_a, 1);
        chk("timeout_id_unchanged", id_a, 0);
        repeat (3) @(negedge clk);

        enable = 1'b1;
        wait_level(1'b1, 300, n);
        chk("first_trigger_latency", n, 100);
        handshake(20, 15, 4, 4, ba, bb, bl);
        chk("busy_latency", bl, 3);
        chk("nominal_bits_id0_a", ba, 0);
        chk("nominal_bits_id0_b", bb, 0);
        chk("count_after_first", cnt_a, 1);
        wait_level(1'b1, 300, n);
        chk("period_after_release", n, 99);
        handshake(20, 15, 4, 4, ba, bb, bl);
        chk("nominal_bits_id1_a", ba, 1);
        chk("nominal_bits_id1_b", bb, 1);
        chk("count_after_second", cnt_a, 2);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        busy = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        hi = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            hi += int'(trg_a);
        end
        chk("veto_no_trigger", hi, 0);
        chk("veto_count_3", veto_a, 3);
        busy = 1'b0;
        wait_level(1'b1, 300, n);
        chk("trigger_after_busy_drop", n, 100);
        handshake(20, 15, 4, 4, ba, bb, bl);
        chk("post_veto_bits_a", ba, 2);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        rst_n = 1'b0;
        #1;
        chk("reset2_veto", veto_a, 0);
        chk("reset2_err", err_a, 0);
        chk("reset2_id", id_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int h = 0; h < 17; h++) begin
            pulse();
            chk($sformatf("wrap_id_%0d", h), id_b, h % 16);
            handshake(2, 4, 2, 2, ba, bb, bl);
            chk($sformatf("wrap_bits_%0d", h), bb, h % 16);
        end
        chk("wrap_count", cnt_b, 17);
        chk("wrap_id_final", id_b, 1);

        pulse();
        handshake(5, 5, 4, 4, ba, bb, bl);
        chk("abort_bits", ba, 17);
        chk("abort_trigger_low", trg_a, 0);
        chk("abort_id_incr", id_a, 18);
        pulse();
        handshake(5, 15, 4, 4, ba, bb, bl);
        chk("after_abort_bits", ba, 18);
        chk("after_abort_id", id_a, 19);

        pulse();
        repeat (2) @(negedge clk);
        busy = 1'b1;
        wait_level(1'b0, 20, n);
        trigger_clock = 1'b1;
        repeat (4) @(negedge clk);
        trigger_clock = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_shift_bit0", trg_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_trigger_a", trg_a, 0);
        chk("midreset_trigger_b", trg_b, 0);
        chk("midreset_id", id_a, 0);
        chk("midreset_count", cnt_a, 0);
        busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            hi += int'(trg_a) + int'(trg_b);
        end
        chk("no_residual_trigger", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
